// File: rtl/piso_shifter.sv
// Parallel-in / serial-out shifter: captures an n-bit word on i_load and emits it
// one bit per cycle in the chosen order, flagging busy and the final bit.
module piso_shifter #(
  parameter int n         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [n-1:0] i_parallel_in,
  output logic         o_serial_out,
  output logic         o_busy,
  output logic         o_last
);

  localparam int CW = $clog2(n + 1);

  logic [n-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over shift; zero-fill leaves the register clear once the word drains.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (i_load) begin
      sr_d  = i_parallel_in;
      cnt_d = CW'(n);
    end else if (cnt_q != '0) begin
      sr_d  = MSB_FIRST ? {sr_q[n-2:0], 1'b0} : {1'b0, sr_q[n-1:1]};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_serial_out = MSB_FIRST ? sr_q[n-1] : sr_q[0];
  assign o_busy       = (cnt_q != '0);
  assign o_last       = (cnt_q == CW'(1));

endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: MSB-first and LSB-first instances share stimulus and are
// checked against a bit-queue model of the word still to be shown.
module tb_piso_shifter;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_load = 1'b0;
  logic [3:0] i_parallel_in = '0;
  logic so_m, busy_m, last_m, so_l, busy_l, last_l;

  int n_cmp = 0;
  int n_bad = 0;

  bit q_m[$];
  bit q_l[$];

  always #5 i_clk = ~i_clk;

  piso_shifter #(.n(4), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_parallel_in(i_parallel_in),
    .o_serial_out(so_m), .o_busy(busy_m), .o_last(last_m));

  piso_shifter #(.n(4), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_parallel_in(i_parallel_in),
    .o_serial_out(so_l), .o_busy(busy_l), .o_last(last_l));

  // Model: queue of bits still to appear; front is the bit on the wire now.
  task automatic model_edge(input logic ld, input logic [3:0] d);
    if (i_rst) return;
    if (ld) begin
      q_m = {};
      q_l = {};
      for (int i = 3; i >= 0; i--) q_m.push_back(d[i]);
      for (int i = 0; i < 4; i++)  q_l.push_back(d[i]);
    end else begin
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
    end
  endtask

  function automatic logic [5:0] expv();
    logic [5:0] e;
    e[5] = (q_m.size() > 0) ? q_m[0] : 1'b0;
    e[4] = (q_m.size() > 0);
    e[3] = (q_m.size() == 1);
    e[2] = (q_l.size() > 0) ? q_l[0] : 1'b0;
    e[1] = (q_l.size() > 0);
    e[0] = (q_l.size() == 1);
    return e;
  endfunction

  function automatic logic [5:0] actv();
    return {so_m, busy_m, last_m, so_l, busy_l, last_l};
  endfunction

  // Drive at the falling edge, clock, then return at the next falling edge.
  task automatic cyc(input logic ld, input logic [3:0] d);
    i_load = ld;
    i_parallel_in = d;
    @(posedge i_clk);
    model_edge(ld, d);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    q_m = {}; q_l = {};
    #1;
    n_cmp++;
    if (actv() !== 6'b0) begin
      n_bad++; $display("FAIL reset_async act=%b exp=%b", actv(), 6'b0);
    end
    cyc(1'b0, 4'h0);
    i_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 4'($urandom));
      n_cmp++;
      if (actv() !== 6'b0) begin
        n_bad++; $display("FAIL reset_idle cyc=%0d act=%b exp=%b", k, actv(), 6'b0);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] sm, sl;
    for (int k = 0; k < 6; k++) begin
      cyc(k == 0, 4'b1010);
      n_cmp++;
      if (actv() !== expv()) begin
        n_bad++; $display("FAIL single cyc=%0d act=%b exp=%b", k, actv(), expv());
      end
      if (k < 4) begin
        sm[3-k] = so_m;
        sl[3-k] = so_l;
      end
    end
    n_cmp++;
    if (sm !== 4'b1010) begin
      n_bad++; $display("FAIL single_msb_seq act=%b exp=%b", sm, 4'b1010);
    end
    n_cmp++;
    if (sl !== 4'b0101) begin
      n_bad++; $display("FAIL single_lsb_seq act=%b exp=%b", sl, 4'b0101);
    end
  endtask

  task automatic test_lsb();
    logic [3:0] sl;
    for (int k = 0; k < 5; k++) begin
      cyc(k == 0, 4'b1101);
      n_cmp++;
      if (actv() !== expv()) begin
        n_bad++; $display("FAIL lsb cyc=%0d act=%b exp=%b", k, actv(), expv());
      end
      if (k < 4) sl[3-k] = so_l;
    end
    n_cmp++;
    if (sl !== 4'b1011) begin
      n_bad++; $display("FAIL lsb_seq act=%b exp=%b", sl, 4'b1011);
    end
  endtask

  task automatic test_reload();
    logic [5:0] s;
    logic [3:0] d;
    logic       b;
    b = 1'b1;
    for (int k = 0; k < 7; k++) begin
      d = (k == 2) ? 4'b0001 : 4'b1111;
      cyc(k == 0 || k == 2, d);
      n_cmp++;
      if (actv() !== expv()) begin
        n_bad++; $display("FAIL reload cyc=%0d act=%b exp=%b", k, actv(), expv());
      end
      if (k < 6) begin
        s[5-k] = so_m;
        b = b & busy_m;
      end
    end
    n_cmp++;
    if (s !== 6'b110001 || b !== 1'b1) begin
      n_bad++; $display("FAIL reload_seq act=%b busy=%b exp=%b busy=1", s, b, 6'b110001);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 4'b1111);
    cyc(1'b0, 4'b0000);
    #2;
    i_rst = 1'b1;
    q_m = {}; q_l = {};
    #1;
    n_cmp++;
    if (actv() !== 6'b0) begin
      n_bad++; $display("FAIL async_reset act=%b exp=%b", actv(), 6'b0);
    end
    @(negedge i_clk);
    cyc(1'b1, 4'b1011);
    n_cmp++;
    if (actv() !== 6'b0) begin
      n_bad++; $display("FAIL load_in_reset act=%b exp=%b", actv(), 6'b0);
    end
    i_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(k == 0, 4'b0110);
      n_cmp++;
      if (actv() !== expv()) begin
        n_bad++; $display("FAIL post_reset cyc=%0d act=%b exp=%b", k, actv(), expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    logic [3:0] d;
    logic       ld;
    for (int k = 0; k < 9; k++) begin
      ld = (k == 0) || (k == 4);
      d  = (k == 4) ? 4'b0110 : 4'b1000;
      if (k == 4) begin
        n_cmp++;
        if (last_m !== 1'b1) begin
          n_bad++; $display("FAIL b2b_last act=%b exp=1", last_m);
        end
      end
      cyc(ld, d);
      n_cmp++;
      if (actv() !== expv()) begin
        n_bad++; $display("FAIL b2b cyc=%0d act=%b exp=%b", k, actv(), expv());
      end
      if (k < 8) s[7-k] = so_m;
    end
    n_cmp++;
    if (s !== 8'b10000110) begin
      n_bad++; $display("FAIL b2b_seq act=%b exp=%b", s, 8'b10000110);
    end
  endtask

  task automatic test_hold_load();
    for (int k = 0; k < 8; k++) begin
      cyc(k < 5, 4'($urandom));
      n_cmp++;
      if (actv() !== expv()) begin
        n_bad++; $display("FAIL hold_load cyc=%0d act=%b exp=%b", k, actv(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        i_rst = 1'b1;
        q_m = {}; q_l = {};
      end
      cyc($urandom_range(0, 3) == 0, 4'($urandom));
      i_rst = 1'b0;
      n_cmp++;
      if (actv() !== expv()) begin
        n_bad++; $display("FAIL random cyc=%0d act=%b exp=%b", k, actv(), expv());
      end
    end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_single();
    test_lsb();
    test_reload();
    test_async_reset();
    test_back_to_back();
    test_hold_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 Parameter n, default 4, meaning parallel word width in bits; n SHALL be >= 2.
REQ-002 Parameter MSB_FIRST, default 1, meaning shift order: 1 = bit n-1 first, 0 = bit 0 first.
REQ-003 Port i_clk  input  1  meaning the single clock; all state SHALL update on the rising edge.
REQ-004 Port i_rst  input  1  meaning asynchronous, active-high reset.
REQ-005 Port i_load  input  1  meaning load strobe, sampled on the rising edge of i_clk.
REQ-006 Port i_parallel_in  input  n  meaning parallel word, captured when i_load is sampled high.
REQ-007 Port o_serial_out  output  1  meaning current serial bit, driven directly from a register (no combinational path from inputs).
REQ-008 Port o_busy  output  1  meaning a loaded word is still being shifted out.
REQ-009 Port o_last  output  1  meaning o_serial_out carries the final bit of the current word.

Function
REQ-010 Internal state SHALL be an n-bit shift register plus a bit counter of width ceil(log2(n+1)).
REQ-011 i_load = 1 at a rising edge SHALL capture i_parallel_in into the shift register, set the counter to n, and set o_busy = 1.
REQ-012 o_serial_out SHALL present the first bit (bit n-1 if MSB_FIRST, else bit 0) in the cycle immediately after the load edge (latency 1 cycle).
REQ-013 Each subsequent rising edge with i_load = 0 and counter > 0 SHALL shift the register one position toward the output end, fill the vacated position with 0, and decrement the counter.
REQ-014 A loaded word SHALL therefore appear on o_serial_out as n consecutive cycles, one bit per cycle, in the selected order.
REQ-015 o_last SHALL be 1 only while counter = 1 (final bit displayed); o_busy SHALL be 1 while counter > 0.
REQ-016 When the counter reaches 0: o_busy = 0, o_last = 0, and o_serial_out = 0; the block SHALL stay idle until the next load.
REQ-017 i_load asserted while o_busy = 1 SHALL abort the current word and restart with the new word (load has priority over shift).
REQ-018 i_load held high for multiple cycles SHALL reload every cycle, so o_serial_out repeatedly shows the first bit of the current i_parallel_in.
REQ-019 i_parallel_in SHALL be ignored in any cycle where i_load = 0.
REQ-020 Back-to-back words SHALL be supported: a load coinciding with o_last = 1 SHALL start the next word with no idle cycle.

Reset
REQ-021 i_rst = 1 SHALL immediately, without waiting for a clock edge, clear the shift register and counter to 0, forcing o_serial_out = 0, o_busy = 0, o_last = 0.
REQ-022 Reset asserted mid-word SHALL discard the remaining bits; i_load sampled while i_rst = 1 SHALL be ignored.
REQ-023 After i_rst deasserts, the first load SHALL behave exactly as described in REQ-011 and REQ-012.

Verification
REQ-024 Reset then idle: i_rst = 1 for 1 cycle, then release with i_load = 0 -> o_serial_out = 0 and o_busy = 0 on every cycle.
REQ-025 Single word: n = 4, MSB_FIRST = 1, load 4'b1010 for 1 cycle -> o_serial_out = 1,0,1,0 over the next 4 cycles; o_last = 1 on the 4th cycle; then o_serial_out = 0 and o_busy = 0.
REQ-026 LSB order: MSB_FIRST = 0, load 4'b1101 -> o_serial_out = 1,0,1,1.
REQ-027 Reload mid-word: load 4'b1111, and after 2 bits load 4'b0001 -> o_serial_out = 1,1,0,0,0,1, with o_busy held at 1 throughout.
REQ-028 Asynchronous reset: load 4'b1111, then assert i_rst between clock edges after 1 bit -> o_serial_out = 0 and o_busy = 0 before the next edge.
REQ-029 Back-to-back: load 4'b1000, and in the cycle where o_last = 1 load 4'b0110 -> o_serial_out = 1,0,0,0,0,1,1,0 with no gap.
